// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two bus masters onto one single-ported synchronous RAM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin priority; the default is fixed priority (master 0 wins).
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rstrb,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wmask,
    output logic [31:0]       m0_rdata,
    output logic              m0_done,

    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rstrb,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wmask,
    output logic [31:0]       m1_rdata,
    output logic              m1_done,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rstrb,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,

    output logic [1:0]        arb_grant,
    output logic [1:0]        dbg_state
);

    // Handshake: a master raises rstrb and/or wmask and holds addr/wdata/wmask
    // stable until its done pulse; a request still high in the cycle after done
    // is taken as a new transaction. Inputs are captured once, at grant.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic              rstrb_q, rstrb_d;
    logic [1:0]        done_q, done_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;

    logic              req0, req1;
    logic              win1;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wmask;
    logic              sel_rstrb;

    assign req0 = m0_rstrb | (|m0_wmask);
    assign req1 = m1_rstrb | (|m1_wmask);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // prio_q high means master 1 wins the next simultaneous request.
    logic prio_q, prio_d;

    assign win1 = req1 & (~req0 | prio_q);

    always_comb begin
        prio_d = prio_q;
        if (state_q == ST_IDLE && (req0 || req1)) begin
            prio_d = ~win1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign win1 = req1 & ~req0;
`endif

    always_comb begin
        sel_addr  = win1 ? m1_addr  : m0_addr;
        sel_wdata = win1 ? m1_wdata : m0_wdata;
        sel_wmask = win1 ? m1_wmask : m0_wmask;
        sel_rstrb = win1 ? m1_rstrb : m0_rstrb;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = 4'h0;
        rstrb_d  = 1'b0;
        done_d   = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_d = win1 ? 2'b10 : 2'b01;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wmask_d = sel_wmask;
                    rstrb_d = sel_rstrb;
                    // A pure write completes in the RAM access cycle itself.
                    if (!sel_rstrb) begin
                        done_d = win1 ? 2'b10 : 2'b01;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rstrb_q) begin
                    done_d  = grant_q;
                    state_d = ST_RESP;
                end else begin
                    grant_d = 2'b00;
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (grant_q[0]) begin
                    rdata0_d = mem_rdata;
                end
                if (grant_q[1]) begin
                    rdata1_d = mem_rdata;
                end
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            wmask_q  <= 4'h0;
            rstrb_q  <= 1'b0;
            done_q   <= 2'b00;
            rdata0_q <= 32'h0;
            rdata1_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            rstrb_q  <= rstrb_d;
            done_q   <= done_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // RAM data arrives the cycle after the strobe; bypass it so rdata is valid with done.
    assign m0_rdata  = (state_q == ST_RESP && grant_q[0]) ? mem_rdata : rdata0_q;
    assign m1_rdata  = (state_q == ST_RESP && grant_q[1]) ? mem_rdata : rdata1_q;
    assign m0_done   = done_q[0];
    assign m1_done   = done_q[1];
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign mem_rstrb = rstrb_q;
    assign arb_grant = grant_q;
    assign dbg_state = state_q;

    a_done_onehot: assert property (@(posedge clk) disable iff (!resetn)
        done_q != 2'b11);
    a_strobe_in_issue: assert property (@(posedge clk) disable iff (!resetn)
        (rstrb_q || (|wmask_q)) |-> (state_q == ST_ISSUE));

endmodule
